// File: rtl/dff_checker.sv
// -----------------------------------------------------------------------------
// dff_checker
//
// Purpose:
//   Watches the din / dut_resetn / dout pins of a D flip-flop with an
//   active-low synchronous reset. Over a run of num_pkts cycles it checks
//   that dout follows the value the flop should have captured one cycle
//   earlier. It counts mismatches and records the index of the first one.
//
// Parameters:
//   WIDTH          - width of the observed din/dout data
//   CNT_W          - width of num_pkts and of all counters
//
// Ports:
//   clk            - single clock, all state updates on the rising edge
//   reset          - synchronous, active-high checker reset
//   start          - one-cycle run request, honoured only in IDLE or DONE
//   num_pkts       - number of cycles to compare, sampled when start is taken
//   dut_resetn     - observed flop reset (active-low, synchronous)
//   din            - observed flop data input
//   dout           - observed flop data output
//   busy           - high while priming or checking
//   done           - high while in DONE
//   pass           - high in DONE when no mismatch was seen
//   pkt_cnt        - cycles compared in the current run
//   err_cnt        - mismatches in the current run, saturating
//   err_valid      - a first mismatch has been recorded
//   first_err_idx  - pkt_cnt value at the first mismatch
// -----------------------------------------------------------------------------
module dff_checker #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_pkts,
    input  logic             dut_resetn,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] dout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_valid,
    output logic [CNT_W-1:0] first_err_idx
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRIME,
        S_CHECK,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] pkt_q, pkt_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic             err_valid_q, err_valid_d;
    logic [CNT_W-1:0] first_idx_q, first_idx_d;
    logic [WIDTH-1:0] exp_q, exp_d;

    logic [CNT_W-1:0] pkt_inc;
    logic [WIDTH-1:0] exp_next;
    logic             mismatch;

    // The value the flop should present on the next edge. When its reset is
    // low it must have cleared, whatever din was.
    assign exp_next = dut_resetn ? din : '0;
    assign pkt_inc  = pkt_q + CNT_W'(1);
    // Case-inequality, so X/Z on dout is a mismatch in simulation.
    assign mismatch = (dout !== exp_q);

    // NOTE: every signal written below gets a default first. A path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        pkt_d       = pkt_q;
        err_d       = err_q;
        err_valid_d = err_valid_q;
        first_idx_d = first_idx_q;
        exp_d       = exp_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    num_d       = num_pkts;
                    pkt_d       = '0;
                    err_d       = '0;
                    err_valid_d = 1'b0;
                    first_idx_d = '0;
                    state_d     = (num_pkts != '0) ? S_PRIME : S_DONE;
                end
            end

            // Captures the first expected value, so the first CHECK cycle
            // has something to compare against.
            S_PRIME: begin
                exp_d   = exp_next;
                state_d = S_CHECK;
            end

            S_CHECK: begin
                pkt_d = pkt_inc;
                exp_d = exp_next;
                if (mismatch) begin
                    if (err_q != '1) begin
                        err_d = err_q + CNT_W'(1);
                    end
                    if (!err_valid_q) begin
                        err_valid_d = 1'b1;
                        first_idx_d = pkt_q;
                    end
                end
                if (pkt_inc == num_q) begin
                    state_d = S_DONE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments. All flops then
    // update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            num_q       <= '0;
            pkt_q       <= '0;
            err_q       <= '0;
            err_valid_q <= 1'b0;
            first_idx_q <= '0;
            exp_q       <= '0;
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            pkt_q       <= pkt_d;
            err_q       <= err_d;
            err_valid_q <= err_valid_d;
            first_idx_q <= first_idx_d;
            exp_q       <= exp_d;
        end
    end

    assign busy          = (state_q == S_PRIME) || (state_q == S_CHECK);
    assign done          = (state_q == S_DONE);
    assign pass          = done && (err_q == '0);
    assign pkt_cnt       = pkt_q;
    assign err_cnt       = err_q;
    assign err_valid     = err_valid_q;
    assign first_err_idx = first_idx_q;

endmodule

// File: tb/tb_dff_checker.sv
// -----------------------------------------------------------------------------
// tb_dff_checker
//
// Bench for dff_checker with WIDTH = 8 and CNT_W = 8. Each run is first
// described as arrays: din, dut_resetn and the dout the bench will present on
// each check cycle. The expected result is computed from those arrays and
// queued. The run is then driven. A monitor pops the queue whenever done rises
// and compares. It also checks that the result holds steady while done stays
// high.
// -----------------------------------------------------------------------------
module tb_dff_checker;

    localparam int WIDTH = 8;
    localparam int CNT_W = 8;
    localparam int CAP   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [CNT_W-1:0] num_pkts;
    logic             dut_resetn;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] pkt_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic             err_valid;
    logic [CNT_W-1:0] first_err_idx;

    dff_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .num_pkts      (num_pkts),
        .dut_resetn    (dut_resetn),
        .din           (din),
        .dout          (dout),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .pkt_cnt       (pkt_cnt),
        .err_cnt       (err_cnt),
        .err_valid     (err_valid),
        .first_err_idx (first_err_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pkt;
        int err;
        int ev;
        int fi;
        int pass;
        int busy_cycles;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Stimulus for one run: din/rn indexed by reload slot (0 = PRIME,
    // j+1 = check cycle j), dout indexed by check cycle.
    logic [WIDTH-1:0] din_a  [0:255];
    bit               rn_a   [0:255];
    logic [WIDTH-1:0] dout_a [0:255];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Healthy-flop stimulus. err_pct of the check cycles get a nonzero XOR
    // mask on dout. rn_low_pct of the cycles hold the flop reset low.
    task automatic fill_random(input int n, input int err_pct, input int rn_low_pct);
        logic [WIDTH-1:0] good;
        logic [WIDTH-1:0] mask;
        for (int j = 0; j <= n && j < 256; j++) begin
            din_a[j] = WIDTH'($urandom);
            rn_a[j]  = ($urandom_range(99) >= rn_low_pct);
        end
        for (int j = 0; j < n; j++) begin
            good      = rn_a[j] ? din_a[j] : '0;
            mask      = ($urandom_range(99) < err_pct) ? WIDTH'($urandom_range(255, 1)) : '0;
            dout_a[j] = good ^ mask;
        end
    endtask

    // Reference result: a check cycle j mismatches when the presented dout
    // differs from what the flop should hold after slot j.
    task automatic predict(input int n);
        exp_t             e;
        logic [WIDTH-1:0] want;
        int               first;
        e.err = 0;
        first = -1;
        for (int j = 0; j < n; j++) begin
            want = rn_a[j] ? din_a[j] : '0;
            if (dout_a[j] !== want) begin
                if (first < 0) first = j;
                if (e.err < CAP) e.err++;
            end
        end
        e.pkt         = n;
        e.ev          = (first >= 0) ? 1 : 0;
        e.fi          = (first >= 0) ? first : 0;
        e.pass        = (e.err == 0) ? 1 : 0;
        e.busy_cycles = (n == 0) ? 0 : n + 1;
        sb_q.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_pass"}, int'(pass), 0);
        check({tag, "_pkt"},  int'(pkt_cnt), 0);
        check({tag, "_err"},  int'(err_cnt), 0);
        check({tag, "_ev"},   int'(err_valid), 0);
        check({tag, "_fi"},   int'(first_err_idx), 0);
    endtask

    // Drives one run. Must be called with the DUT in IDLE or DONE. A
    // non-negative abort_at raises reset before that check cycle's edge.
    task automatic run(input int n, input int abort_at, input bit mid_start);
        if (abort_at < 0) predict(n);
        start    = 1'b1;
        num_pkts = CNT_W'(n);
        @(posedge clk);
        #1;
        start      = 1'b0;
        num_pkts   = CNT_W'($urandom);
        din        = din_a[0];
        dut_resetn = rn_a[0];
        @(negedge clk);
        check("accept_busy", int'(busy), (n != 0) ? 1 : 0);
        check("accept_done", int'(done), (n == 0) ? 1 : 0);
        if (n == 0) return;
        @(posedge clk);
        #1;
        for (int j = 0; j < n; j++) begin
            if (j == abort_at) begin
                reset = 1'b1;
                start = 1'b1;
                @(posedge clk);
                @(negedge clk);
                check_all_zero("abort");
                @(posedge clk);
                @(negedge clk);
                check("start_in_reset", int'(busy), 0);
                reset = 1'b0;
                start = 1'b0;
                return;
            end
            dout       = dout_a[j];
            din        = (j + 1 < 256) ? din_a[j+1] : '0;
            dut_resetn = (j + 1 < 256) ? rn_a[j+1] : 1'b1;
            start      = mid_start && (j == 2);
            num_pkts   = CNT_W'($urandom);
            @(posedge clk);
            #1;
            start = 1'b0;
        end
    endtask

    task automatic idle();
        repeat ($urandom_range(2)) @(posedge clk);
        #1;
    endtask

    // Monitor: a rising done presents a result. It is held until start.
    initial begin
        exp_t cur;
        bit   done_prev   = 1'b0;
        int   busy_cycles = 0;
        cur = '{pkt: 0, err: 0, ev: 0, fi: 0, pass: 0, busy_cycles: 0};
        forever begin
            @(negedge clk);
            if (reset) begin
                busy_cycles = 0;
                done_prev   = 1'b0;
            end else begin
                if (busy) busy_cycles++;
                if (done) begin
                    if (!done_prev) begin
                        check("sb_pending", int'(sb_q.size() != 0), 1);
                        if (sb_q.size() != 0) cur = sb_q.pop_front();
                        check("busy_cycles", busy_cycles, cur.busy_cycles);
                        busy_cycles = 0;
                    end
                    check("done_busy", int'(busy), 0);
                    check("pkt_cnt", int'(pkt_cnt), cur.pkt);
                    check("err_cnt", int'(err_cnt), cur.err);
                    check("err_valid", int'(err_valid), cur.ev);
                    check("first_err_idx", int'(first_err_idx), cur.fi);
                    check("pass", int'(pass), cur.pass);
                end
                done_prev = done;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        num_pkts   = '0;
        din        = '0;
        dout       = '0;
        dut_resetn = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");

        // Zero-length run from IDLE, taken on the first edge after reset.
        reset = 1'b0;
        fill_random(0, 0, 0);
        run(0, -1, 1'b0);
        idle();

        // Healthy flop, ten cycles.
        fill_random(10, 0, 0);
        run(10, -1, 1'b0);
        idle();

        // Inverted dout on check cycles 3 and 7.
        fill_random(10, 0, 0);
        dout_a[3] = ~dout_a[3];
        dout_a[7] = ~dout_a[7];
        run(10, -1, 1'b0);
        idle();

        // Flop reset low for two slots, flop output clears correctly.
        fill_random(10, 0, 0);
        rn_a[4]   = 1'b0;
        rn_a[5]   = 1'b0;
        dout_a[4] = '0;
        dout_a[5] = '0;
        run(10, -1, 1'b0);
        idle();

        // Same, but dout stuck high and din all ones.
        for (int j = 0; j <= 10; j++) begin
            din_a[j]  = '1;
            rn_a[j]   = 1'b1;
            dout_a[j] = '1;
        end
        rn_a[4] = 1'b0;
        rn_a[5] = 1'b0;
        run(10, -1, 1'b0);
        idle();

        // start pulsed during CHECK is ignored.
        fill_random(10, 20, 10);
        run(10, -1, 1'b1);
        idle();

        // Reset at check cycle 5 after an early mismatch, then a short run.
        fill_random(10, 0, 0);
        dout_a[1] = dout_a[1] ^ 8'h01;
        run(10, 5, 1'b0);
        fill_random(4, 25, 0);
        run(4, -1, 1'b0);
        idle();

        // Every cycle mismatching over the longest run.
        fill_random(255, 0, 0);
        for (int j = 0; j < 255; j++) dout_a[j] = ~dout_a[j];
        run(255, -1, 1'b0);
        idle();

        // Randomized runs.
        for (int r = 0; r < 12; r++) begin
            int n;
            n = 1 + $urandom_range(19);
            fill_random(n, 15, 15);
            run(n, -1, bit'($urandom_range(1)));
            idle();
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("sb_drain", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dff_checker.md
DFF_CHECKER -- requirements
Module: dff_checker

Interface
REQ-001 Parameter WIDTH, default 1, bit width of the observed din/dout data.
REQ-002 Parameter CNT_W, default 8, width of the packet/error counters and of num_pkts.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset of the checker.
REQ-005 start  input  1  one-cycle request to begin a check run; honoured only in IDLE or DONE.
REQ-006 num_pkts  input  CNT_W  number of cycles to check; sampled when start is accepted.
REQ-007 dut_resetn  input  1  observed DUT reset; active-low, synchronous in the DUT.
REQ-008 din  input  WIDTH  observed DUT data input.
REQ-009 dout  input  WIDTH  observed DUT data output.
REQ-010 busy  output  1  high in PRIME and CHECK.
REQ-011 done  output  1  high while in DONE.
REQ-012 pass  output  1  high in DONE when err_cnt == 0; low otherwise.
REQ-013 pkt_cnt  output  CNT_W  number of cycles compared in the current run.
REQ-014 err_cnt  output  CNT_W  number of mismatches in the current run; saturates at all-ones.
REQ-015 err_valid  output  1  high once the first mismatch of the run has been recorded.
REQ-016 first_err_idx  output  CNT_W  value of pkt_cnt at the first mismatch; valid when err_valid = 1.

Function
REQ-017 The FSM SHALL have states IDLE, PRIME, CHECK, DONE.
REQ-018 IDLE/DONE + start SHALL latch num_pkts and clear pkt_cnt, err_cnt, err_valid and first_err_idx; the next state is PRIME if num_pkts != 0, else DONE with pass = 1.
REQ-019 PRIME SHALL last exactly one cycle, load exp <= dut_resetn ? din : 0, then go to CHECK.
REQ-020 Each CHECK cycle SHALL compare dout with exp, increment pkt_cnt by 1 and reload exp <= dut_resetn ? din : 0.
REQ-021 A mismatch SHALL increment err_cnt (saturating) and, if err_valid = 0, set err_valid and store the pre-increment pkt_cnt in first_err_idx.
REQ-022 CHECK SHALL go to DONE on the cycle in which the incremented pkt_cnt equals the latched num_pkts; the result is visible on the following edge.
REQ-023 Compare latency SHALL be one cycle: the dout sampled at edge k+1 is checked against the din/dut_resetn sampled at edge k.
REQ-024 start asserted in PRIME or CHECK SHALL be ignored, and num_pkts changes after acceptance SHALL have no effect.
REQ-025 DONE SHALL hold done, pass, pkt_cnt, err_cnt, err_valid and first_err_idx stable until start or reset.
REQ-026 DONE + start SHALL begin a new run in the same cycle per REQ-018, and done SHALL drop on the next edge.
REQ-027 dut_resetn low during CHECK SHALL NOT abort the run; the expected value for the following cycle is 0.
REQ-028 Comparisons SHALL be bitwise over all WIDTH bits; any X/Z on dout counts as a mismatch (case-inequality).

Reset
REQ-029 reset high at a rising edge SHALL force IDLE and drive busy = 0, done = 0, pass = 0, pkt_cnt = 0, err_cnt = 0, err_valid = 0, first_err_idx = 0 and exp = 0.
REQ-030 reset in any state, including mid-CHECK, SHALL discard the run with no residual counts, and start is ignored while reset is high.
REQ-031 After reset deasserts, the checker SHALL accept start on the first subsequent edge.

Verification
REQ-032 Healthy DFF, dut_resetn = 1, num_pkts = 10, random din -> busy for 11 cycles, then done = 1, pass = 1, pkt_cnt = 10, err_cnt = 0.
REQ-033 dout forced inverted for check cycles 3 and 7 of num_pkts = 10 -> err_cnt = 2, err_valid = 1, first_err_idx = 3, pass = 0.
REQ-034 dut_resetn low for 2 cycles mid-run while DUT outputs 0 -> err_cnt = 0; the same with dout stuck at 1 -> err_cnt = 2.
REQ-035 num_pkts = 0 with start -> DONE on the next edge with pass = 1 and pkt_cnt = 0; start pulsed mid-CHECK -> ignored, counts unaffected.
REQ-036 reset asserted at check cycle 5 of 10 -> all outputs 0 in IDLE next cycle; a new run with num_pkts = 4 completes with pkt_cnt = 4.
REQ-037 WIDTH = 8, num_pkts = 255, every cycle mismatching -> err_cnt = 255, first_err_idx = 0, pkt_cnt = 255.
